// File: rtl/njesia_kontrollit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB/HALT, drives ALU,
// memory, register-file and PC strobes, and counts retired instructions.
module njesia_kontrollit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [2:0]  ALUOp,
  output logic        ALUSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        Halted,
  output logic        IllegalOp,
  output logic [2:0]  State,
  output logic [15:0] RetiredCount
);

  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    HALT   = 3'b101
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_SLLI  = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_SW    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic is_legal(input logic [3:0] op, input logic [2:0] fn);
    case (op)
      OP_RTYPE:                                      is_legal = (fn != 3'b111);
      OP_ADDI, OP_SLLI, OP_LW, OP_SW, OP_BEQ, OP_HALT: is_legal = 1'b1;
      default:                                       is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_sel(input logic [3:0] op, input logic [2:0] fn);
    case (op)
      OP_RTYPE:              alu_sel = fn;
      OP_ADDI, OP_LW, OP_SW: alu_sel = 3'b010;
      OP_SLLI:               alu_sel = 3'b100;
      OP_BEQ:                alu_sel = 3'b110;
      default:               alu_sel = 3'b000;
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  opcode_r;
  logic [2:0]  funct_r;
  logic [15:0] retired_r;
  logic        retire_s;
  logic [2:0]  alu_op_s;
  logic        alu_src_s, iord_s, mem_read_s, mem_write_s, ir_write_s;
  logic        pc_write_s, pc_src_s, reg_write_s, mem_to_reg_s, halted_s, illegal_s;
  logic        unused_s;

  // Instr bits between opcode and funct belong to the datapath, not to control.
  assign unused_s = ^Instr[11:3];

  // State register, decoded-field latches and retire counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= FETCH;
      opcode_r  <= 4'h0;
      funct_r   <= 3'b000;
      retired_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == DECODE) begin
        opcode_r <= Instr[15:12];
        funct_r  <= Instr[2:0];
      end else begin
        opcode_r <= opcode_r;
        funct_r  <= funct_r;
      end
      if (retire_s) begin
        retired_r <= retired_r + 16'd1;
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state and raw strobe decode from state and latched opcode.
  always_comb begin
    state_nxt_s  = state_r;
    retire_s     = 1'b0;
    alu_op_s     = 3'b000;
    alu_src_s    = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    halted_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s = 1'b1;
        if (MemReady) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = DECODE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      // Decode looks at the live IR; the latched copies take over from EXEC on.
      DECODE: begin
        if (!is_legal(Instr[15:12], Instr[2:0])) begin
          illegal_s   = 1'b1;
          state_nxt_s = FETCH;
        end else if (Instr[15:12] == OP_HALT) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      EXEC: begin
        alu_op_s  = alu_sel(opcode_r, funct_r);
        alu_src_s = (opcode_r == OP_ADDI) || (opcode_r == OP_SLLI) ||
                    (opcode_r == OP_LW)   || (opcode_r == OP_SW);
        if (opcode_r == OP_BEQ) begin
          pc_src_s    = 1'b1;
          pc_write_s  = Zero;
          retire_s    = 1'b1;
          state_nxt_s = FETCH;
        end else if ((opcode_r == OP_LW) || (opcode_r == OP_SW)) begin
          state_nxt_s = MEM;
        end else begin
          state_nxt_s = WB;
        end
      end
      MEM: begin
        iord_s      = 1'b1;
        mem_read_s  = (opcode_r == OP_LW);
        mem_write_s = (opcode_r == OP_SW);
        if (!MemReady) begin
          state_nxt_s = MEM;
        end else if (opcode_r == OP_SW) begin
          retire_s    = 1'b1;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = WB;
        end
      end
      WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = (opcode_r == OP_LW);
        retire_s     = 1'b1;
        state_nxt_s  = FETCH;
      end
      HALT: begin
        halted_s    = 1'b1;
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Reset masks every output so an aborted access never strobes in the reset cycle.
  always_comb begin
    if (Reset) begin
      ALUOp        = 3'b000;
      ALUSrc       = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      PCSrc        = 1'b0;
      RegWrite     = 1'b0;
      MemToReg     = 1'b0;
      Halted       = 1'b0;
      IllegalOp    = 1'b0;
      State        = 3'b000;
      RetiredCount = 16'h0000;
    end else begin
      ALUOp        = alu_op_s;
      ALUSrc       = alu_src_s;
      IorD         = iord_s;
      MemRead      = mem_read_s;
      MemWrite     = mem_write_s;
      IRWrite      = ir_write_s;
      PCWrite      = pc_write_s;
      PCSrc        = pc_src_s;
      RegWrite     = reg_write_s;
      MemToReg     = mem_to_reg_s;
      Halted       = halted_s;
      IllegalOp    = illegal_s;
      State        = state_r;
      RetiredCount = retired_r;
    end
  end

endmodule

// File: doc/njesia_kontrollit.md
# njesia_kontrollit

Multi-cycle control unit for the 16-bit CPU. It sequences every instruction through fetch, decode, execute, memory and write-back. It drives the ALU operation select and the 3-bit ALU result-mux select using the shared ALU encoding, and generates all register-file, memory and PC strobes. It waits on a memory-ready handshake and keeps a count of retired instructions.

## Interface
- No parameters. The ALU encoding is fixed: AND 000, OR 001, XOR 011, ADD 010, SUB 110, SLLI 100, ROR 101.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- Instr  in  16  current IR contents. Opcode is Instr[15:12]; R-type funct is Instr[2:0].
- Zero  in  1  ALU zero flag, valid during EXEC.
- MemReady  in  1  memory completes the current access this cycle.
- ALUOp  out  3  ALU operation and result-mux select, in the encoding above.
- ALUSrc  out  1  0 = register B, 1 = immediate.
- IorD  out  1  memory address source: 0 = PC, 1 = ALU result.
- MemRead / MemWrite  out  1 each  memory strobes.
- IRWrite, PCWrite, PCSrc  out  1 each  IR load; PC load; PC source (0 = PC+2, 1 = branch target).
- RegWrite, MemToReg  out  1 each  register write; write-back source (1 = memory data).
- Halted  out  1  high in the HALT state.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode or funct.
- State  out  3  debug state code.
- RetiredCount  out  16  number of completed instructions.

## Operation
- State codes: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 101.
- Opcode decode:
  - 0000 R-type: ALUOp = funct. Funct 111 is illegal.
  - 0001 ADDI: ALUOp 010, ALUSrc 1.
  - 0010 SLLI: ALUOp 100, ALUSrc 1.
  - 0011 LW: ALUOp 010, ALUSrc 1.
  - 0100 SW: ALUOp 010, ALUSrc 1.
  - 0101 BEQ: ALUOp 110, ALUSrc 0.
  - 1111 HALT.
  - All other opcodes are illegal.
- FETCH: MemRead=1, IorD=0.
  - MemReady=1: assert IRWrite=1 and PCWrite=1 (PCSrc=0), go to DECODE.
  - MemReady=0: hold in FETCH with all strobes unchanged.
- DECODE: latch Instr[15:12] and Instr[2:0] into internal registers. All later states use the latched copies, so Instr may change after DECODE.
  - Illegal opcode or funct: pulse IllegalOp for this cycle, go to FETCH, no retire.
  - HALT opcode: go to HALT.
  - Otherwise: go to EXEC.
- EXEC: drive ALUOp and ALUSrc for the latched opcode.
  - BEQ: PCSrc=1, PCWrite=Zero, then FETCH and retire.
  - LW and SW: go to MEM.
  - All others: go to WB.
- MEM: IorD=1 with MemRead (LW) or MemWrite (SW) held until MemReady=1.
  - On MemReady, SW goes to FETCH and retires; LW goes to WB.
- WB: RegWrite=1, MemToReg=1 for LW only, then FETCH and retire.
- HALT: all strobes 0 and Halted=1. The block stays in HALT until Reset.
- Retire rule: RetiredCount increments by 1 on each transition into FETCH that completes an instruction. It wraps from FFFF to 0000. Illegal instructions are not counted.
- Unused ALUOp value: 000 whenever the current state does not drive the ALU.

## Timing
- Control outputs are combinational from the state and latched opcode. PCWrite in EXEC also depends on Zero, and the FETCH/MEM transitions depend on MemReady.
- Reset behaviour:
  - While Reset=1, every output is 0, including RetiredCount and State.
  - The first cycle after Reset falls is FETCH, with MemRead=1.
  - Reset asserted in any state, including mid-MEM or HALT, aborts the instruction. No RegWrite or MemWrite is issued in the reset cycle, and nothing retires.
- Latency with MemReady=1 throughout:
  - R-type, ADDI, SLLI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle with MemReady=0 in FETCH or MEM adds exactly one cycle.
- MemRead and MemWrite are never asserted together. The IorD value is stable for the whole time a strobe is held.

## Test plan
- Reset, then R-type ADD (Instr 0x0002), MemReady=1: State goes 000→001→010→100→000. ALUOp=010 in EXEC, RegWrite=1 for exactly one cycle, RetiredCount=1.
- LW (0x3xxx) with MemReady low for 3 cycles in MEM: IorD=1 and MemRead held 4 cycles, then WB with MemToReg=1. Total latency 8 cycles.
- BEQ (0x5xxx): with Zero=1 in EXEC, PCWrite=1 and PCSrc=1. With Zero=0, PCWrite=0. Both return to FETCH after 3 cycles and retire.
- Illegal opcode 0x7000 and R-type funct 111 (0x0007): IllegalOp pulses one cycle in DECODE, next state is FETCH, RetiredCount unchanged, RegWrite never asserted.
- HALT 0xF000: Halted=1 and State=101 stay indefinitely. Asserting Reset returns the block to FETCH on the cycle after Reset falls, with RetiredCount=0.
- Force RetiredCount to 0xFFFF with a run of 65535 ADDIs, then retire one more: RetiredCount=0x0000. Reset asserted mid-SW in MEM: MemWrite drops to 0 in the reset cycle.
